// File: rtl/comparator4_sweep_checker_if.sv
// Comparator bus between the sweep checker (master) and the
// comparator under test (slave). Operand bit 0 is the MSB.
`timescale 1ns/1ps
interface comparator4_sweep_checker_if #(
    parameter int unsigned WIDTH = 4
);
    logic [0:WIDTH-1] a_o;
    logic [0:WIDTH-1] b_o;
    logic             g_i;
    logic             e_i;
    logic             l_i;

    modport master (output a_o, b_o, input g_i, e_i, l_i);
    modport slave  (input a_o, b_o, output g_i, e_i, l_i);
endinterface

// File: rtl/comparator4_sweep_checker.sv
// Built-in self-test for a magnitude comparator. Sweeps every (a,b)
// pair a-major/b-minor, holds each pair SETTLE+1 cycles, samples g/e/l
// on the last held cycle and counts results that differ from an
// internal golden compare.
// Optional macro SWEEP_CKR_CAPTURE_EN adds fail_a/fail_b/fail_gel,
// which latch the first mismatching pair of a sweep.
`timescale 1ns/1ps
module comparator4_sweep_checker #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    comparator4_sweep_checker_if.master       cmp,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [2*WIDTH:0]                  err_cnt
`ifdef SWEEP_CKR_CAPTURE_EN
    ,
    output logic [0:WIDTH-1]                  fail_a,
    output logic [0:WIDTH-1]                  fail_b,
    output logic [2:0]                        fail_gel
`endif
);

    localparam int unsigned    HW        = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(SETTLE);
    localparam logic [WIDTH-1:0] MAXV    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [HW-1:0]    r_hold;
    logic [2*WIDTH:0] r_err;
    logic [2:0]       w_gel;
    logic [2:0]       w_gold;
    logic             w_mismatch;
    logic             w_sample;
    logic             w_last;
    logic             w_launch;

    assign w_gel      = {cmp.g_i, cmp.e_i, cmp.l_i};
    assign w_gold     = {r_a > r_b, r_a == r_b, r_a < r_b};
    assign w_mismatch = (w_gel != w_gold);
    assign w_sample   = (r_state == S_RUN) && (r_hold == HOLD_LAST);
    assign w_last     = (r_a == MAXV) && (r_b == MAXV);
    assign w_launch   = start && (r_state != S_RUN);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: start is ignored while a sweep is running.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_sample && w_last) w_next = S_DONE;
            S_DONE:  if (start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand sweep, hold-window counter and mismatch count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_hold <= '0;
            r_err  <= '0;
        end else if (w_launch) begin
            r_a    <= '0;
            r_b    <= '0;
            r_hold <= '0;
            r_err  <= '0;
        end else if (r_state == S_RUN) begin
            if (w_sample) begin
                r_hold <= '0;
                if (w_mismatch) begin
                    r_err <= r_err + 1'b1;
                end
                // The last pair stays on the bus through DONE.
                if (!w_last) begin
                    r_b <= r_b + 1'b1;
                    if (r_b == MAXV) begin
                        r_a <= r_a + 1'b1;
                    end
                end
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign cmp.a_o = r_a;
    assign cmp.b_o = r_b;
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign pass    = (r_state == S_DONE) && (r_err == '0);
    assign err_cnt = r_err;

`ifdef SWEEP_CKR_CAPTURE_EN
    logic             r_cap_valid;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic [2:0]       r_fail_gel;

    // Latch the first mismatching pair of a sweep; cleared by a new start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_valid <= 1'b0;
            r_fail_a    <= '0;
            r_fail_b    <= '0;
            r_fail_gel  <= '0;
        end else if (w_launch) begin
            r_cap_valid <= 1'b0;
            r_fail_a    <= '0;
            r_fail_b    <= '0;
            r_fail_gel  <= '0;
        end else if (w_sample && w_mismatch && !r_cap_valid) begin
            r_cap_valid <= 1'b1;
            r_fail_a    <= r_a;
            r_fail_b    <= r_b;
            r_fail_gel  <= w_gel;
        end
    end

    assign fail_a   = r_fail_a;
    assign fail_b   = r_fail_b;
    assign fail_gel = r_fail_gel;
`endif

endmodule
